// File: rtl/fft_bitrev_reorder_pkg.sv
// rtl/fft_bitrev_reorder_pkg.sv - shared constants and index helpers for the FFT bit-reversal reorder stage
//
// Purpose : log2 constant function and bit-reversal helper used by the
//           reorder stage to derive address widths and write addresses.
// Ports   : none (package).

package fft_bitrev_reorder_pkg;

  // Widest index the helpers handle; covers N up to 4096.
  localparam int MAX_LOG_N = 12;

  // Ceiling log2, usable in constant expressions (parameter derivation).
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low log_n bits of x. All MAX_LOG_N bits are mirrored and the
  // result is shifted down, which keeps every bit select constant.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] x,
                                                  input int log_n);
    logic [MAX_LOG_N-1:0] r;
    for (int i = 0; i < MAX_LOG_N; i++) begin
      r[i] = x[MAX_LOG_N-1-i];
    end
    return r >> (MAX_LOG_N - log_n);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// rtl/fft_bitrev_reorder_ram.sv - simple dual-port RAM holding both ping-pong banks
//
// Purpose : 2N-entry storage for the reorder stage; the address MSB selects
//           the bank. Synchronous write, registered synchronous read, no reset
//           on the storage or the read register.
// Ports   : clock      - master clock
//           wr_en_i    - write strobe
//           wr_addr_i  - write address {bank, index}
//           wr_data_i  - write data {re, im}
//           rd_en_i    - read strobe; updates rd_data_o on the next edge
//           rd_addr_i  - read address {bank, index}
//           rd_data_o  - registered read data {re, im}

module reorder_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - reorders bit-reversed FFT output frames into natural bin order
//
// Purpose : accepts N-sample frames in bit-reversed bin order and re-emits
//           each frame in natural order through a ping-pong pair of banks,
//           supporting back-to-back frames without stalls.
// Ports   : clock  - master clock
//           reset  - synchronous active-high reset
//           di_en  - input enable, high for N consecutive cycles per frame
//           di_re  - input real part, bin bitrev(p) at frame position p
//           di_im  - input imaginary part
//           do_en  - output enable, high for N consecutive cycles per frame
//           do_re  - output real part, bin k at output position k
//           do_im  - output imaginary part

module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int               LOG_N = log2_ceil(N);
  localparam logic [LOG_N-1:0] LAST  = LOG_N'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Write side
  logic [LOG_N-1:0] wr_count_q, wr_count_d;
  logic             wr_bank_q, wr_bank_d;
  logic             wr_en;
  logic             commit;
  logic [LOG_N-1:0] wr_index;
  logic [LOG_N:0]   wr_addr;

  // Read side
  logic [0:0]       state_q, state_d;
  logic [LOG_N-1:0] rd_count_q, rd_count_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_en;
  logic [LOG_N:0]   rd_addr;
  logic             do_en_q;
  logic [2*WIDTH-1:0] rd_data;

  // Reset wins over a coincident input sample, so that sample is not stored.
  assign wr_en    = di_en && !reset;
  assign commit   = wr_en && (wr_count_q == LAST);
  assign wr_index = LOG_N'(bitrev(MAX_LOG_N'(wr_count_q), LOG_N));
  assign wr_addr  = {wr_bank_q, wr_index};

  // A gap in di_en restarts the count, discarding any partial frame; the bank
  // only flips on a completed frame, so a fragment is simply overwritten.
  always_comb begin
    wr_count_d = '0;
    wr_bank_d  = wr_bank_q;
    if (di_en) begin
      wr_count_d = wr_count_q + 1'b1;
      if (commit) wr_bank_d = ~wr_bank_q;
    end
  end

  // A commit always (re)starts a read of the just-filled bank. Commits can
  // only coincide with the last read cycle, which gives seamless chaining.
  always_comb begin
    state_d    = state_q;
    rd_count_d = rd_count_q;
    rd_bank_d  = rd_bank_q;
    if (commit) begin
      state_d    = ST_READ;
      rd_count_d = '0;
      rd_bank_d  = wr_bank_q;
    end else if (state_q == ST_READ) begin
      rd_count_d = rd_count_q + 1'b1;
      if (rd_count_q == LAST) state_d = ST_IDLE;
    end
  end

  assign rd_en   = (state_q == ST_READ);
  assign rd_addr = {rd_bank_q, rd_count_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count_q <= '0;
      wr_bank_q  <= 1'b0;
      state_q    <= ST_IDLE;
      rd_count_q <= '0;
      rd_bank_q  <= 1'b0;
      do_en_q    <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      wr_bank_q  <= wr_bank_d;
      state_q    <= state_d;
      rd_count_q <= rd_count_d;
      rd_bank_q  <= rd_bank_d;
      do_en_q    <= rd_en;
    end
  end

  reorder_ram #(
    .ADDR_W(LOG_N + 1),
    .DATA_W(2 * WIDTH)
  ) u_ram (
    .clock    (clock),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i({di_re, di_im}),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  // The RAM read register has no reset; gating with do_en_q gives zero data
  // out of reset and whenever no frame is being emitted.
  assign do_en = do_en_q;
  assign do_re = do_en_q ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign do_im = do_en_q ? rd_data[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder

module tb_fft_bitrev_reorder;

  localparam int NCFG = 3;
  localparam int CFG_N [NCFG] = '{64, 4, 1024};
  localparam int CFG_W [NCFG] = '{16, 24, 24};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst [NCFG];
  logic        en  [NCFG];
  logic [23:0] dre [NCFG];
  logic [23:0] dim [NCFG];
  logic        oen [NCFG];
  logic [23:0] ore [NCFG];
  logic [23:0] oim [NCFG];
  int          pending [NCFG];

  int checks = 0;
  int errors = 0;

  logic        o0_en, o1_en, o2_en;
  logic [15:0] o0_re, o0_im;
  logic [23:0] o1_re, o1_im, o2_re, o2_im;

  fft_bitrev_reorder #(.N(64), .WIDTH(16)) u_dut0 (
    .clock(clock), .reset(rst[0]), .di_en(en[0]),
    .di_re(dre[0][15:0]), .di_im(dim[0][15:0]),
    .do_en(o0_en), .do_re(o0_re), .do_im(o0_im));

  fft_bitrev_reorder #(.N(4), .WIDTH(24)) u_dut1 (
    .clock(clock), .reset(rst[1]), .di_en(en[1]),
    .di_re(dre[1]), .di_im(dim[1]),
    .do_en(o1_en), .do_re(o1_re), .do_im(o1_im));

  fft_bitrev_reorder #(.N(1024), .WIDTH(24)) u_dut2 (
    .clock(clock), .reset(rst[2]), .di_en(en[2]),
    .di_re(dre[2]), .di_im(dim[2]),
    .do_en(o2_en), .do_re(o2_re), .do_im(o2_im));

  always_comb begin
    oen[0] = o0_en; ore[0] = {8'h00, o0_re}; oim[0] = {8'h00, o0_im};
    oen[1] = o1_en; ore[1] = o1_re;          oim[1] = o1_im;
    oen[2] = o2_en; ore[2] = o2_re;          oim[2] = o2_im;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit reversal by repeated halving, independent of the design's helper.
  function automatic int ref_bitrev(input int x, input int logn);
    int r = 0;
    int v = x;
    for (int i = 0; i < logn; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Reference model and checker per configuration. A completed frame (N
  // samples with no gap and no reset) yields bin k = sample at position
  // bitrev(k); output k appears after edge (last_sample_edge + 1 + k).
  for (genvar g = 0; g < NCFG; g++) begin : g_chk
    localparam int GN   = CFG_N[g];
    localparam int GW   = CFG_W[g];
    localparam int GLOG = $clog2(GN);

    int mcyc = 0;
    bit armed = 1'b0;
    bit rst_seen = 1'b0;
    int p;
    logic [GW-1:0] fr_re [$];
    logic [GW-1:0] fr_im [$];
    int            eq_cyc [$];
    logic [GW-1:0] eq_re [$];
    logic [GW-1:0] eq_im [$];

    initial forever begin
      @(posedge clock);
      mcyc++;
      rst_seen = rst[g];
      if (rst[g]) begin
        armed = 1'b1;
        fr_re.delete(); fr_im.delete();
        eq_cyc.delete(); eq_re.delete(); eq_im.delete();
      end else if (!en[g]) begin
        fr_re.delete(); fr_im.delete();
      end else begin
        fr_re.push_back(dre[g][GW-1:0]);
        fr_im.push_back(dim[g][GW-1:0]);
        if (fr_re.size() == GN) begin
          for (int k = 0; k < GN; k++) begin
            p = ref_bitrev(k, GLOG);
            eq_cyc.push_back(mcyc + 1 + k);
            eq_re.push_back(fr_re[p]);
            eq_im.push_back(fr_im[p]);
          end
          fr_re.delete(); fr_im.delete();
        end
      end
      pending[g] = eq_cyc.size();
    end

    initial forever begin
      @(negedge clock);
      if (armed) begin
        if (eq_cyc.size() > 0 && eq_cyc[0] == mcyc) begin
          check($sformatf("cfg%0d_out", g),
                64'({oen[g], 24'(ore[g][GW-1:0]), 24'(oim[g][GW-1:0])}),
                64'({1'b1, 24'(eq_re[0]), 24'(eq_im[0])}));
          void'(eq_cyc.pop_front());
          void'(eq_re.pop_front());
          void'(eq_im.pop_front());
          pending[g] = eq_cyc.size();
        end else begin
          check($sformatf("cfg%0d_idle_en", g), 64'(oen[g]), 64'd0);
        end
        if (rst_seen)
          check($sformatf("cfg%0d_rst_data", g), 64'({ore[g], oim[g]}), 64'd0);
      end
    end
  end

  task automatic drive(input int g, input bit r, input bit e,
                       input logic [23:0] re, input logic [23:0] im);
    @(negedge clock);
    rst[g] = r;
    en[g]  = e;
    dre[g] = re;
    dim[g] = im;
  endtask

  // kind 0: re=bitrev(p), im=-bitrev(p); 1: re=256*f+bitrev(p);
  // 2: random; 3: alternating full-scale extremes.
  task automatic send(input int g, input int len, input int kind, input int f);
    int n  = CFG_N[g];
    int lg = $clog2(n);
    int b;
    for (int q = 0; q < len; q++) begin
      b = ref_bitrev(q, lg);
      case (kind)
        0: drive(g, 1'b0, 1'b1, 24'(b), 24'(-b));
        1: drive(g, 1'b0, 1'b1, 24'(256 * f + b), 24'(f));
        2: drive(g, 1'b0, 1'b1, 24'($urandom), 24'($urandom));
        default: drive(g, 1'b0, 1'b1, (q % 2 == 0) ? 24'h7FFFFF : 24'h800000,
                       (q % 2 == 0) ? 24'h800000 : 24'h7FFFFF);
      endcase
    end
  endtask

  task automatic idle(input int g, input int n);
    repeat (n) drive(g, 1'b0, 1'b0, 24'($urandom), 24'($urandom));
  endtask

  typedef struct {
    logic [23:0] in_re;
    logic [23:0] in_im;
    int          out_k;
    logic [23:0] exp_re;
    logic [23:0] exp_im;
  } vec_t;

  vec_t        tab [4];
  logic [23:0] cap_re [$];
  logic [23:0] cap_im [$];
  int          gap;

  initial begin
    // Input position p of an N=4 frame lands on output position bitrev(p).
    tab[0] = '{24'h7FFFFF, 24'h800000, 0, 24'h7FFFFF, 24'h800000};
    tab[1] = '{24'h800000, 24'h7FFFFF, 2, 24'h800000, 24'h7FFFFF};
    tab[2] = '{24'h000000, 24'hFFFFFF, 1, 24'h000000, 24'hFFFFFF};
    tab[3] = '{24'h123456, 24'hABCDEF, 3, 24'h123456, 24'hABCDEF};

    for (int g = 0; g < NCFG; g++) begin
      rst[g] = 1'b1; en[g] = 1'b0; dre[g] = '0; dim[g] = '0;
    end

    // Reset held 3 cycles with di_en high and random data on cfg0.
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
    @(negedge clock);
    for (int g = 0; g < NCFG; g++) begin
      rst[g] = 1'b0; en[g] = 1'b0;
    end
    idle(0, 4);

    // Single frame, then four contiguous frames.
    send(0, 64, 0, 0);
    idle(0, 70);
    for (int f = 0; f < 4; f++) send(0, 64, 1, f);
    idle(0, 70);

    // Aborted 20-sample fragment followed by a full frame.
    send(0, 20, 2, 0);
    idle(0, 5);
    send(0, 64, 2, 0);
    idle(0, 70);

    // Reset (with di_en high) during output position 30 of the second frame.
    send(0, 64, 2, 0);
    send(0, 64, 2, 0);
    idle(0, 31);
    drive(0, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
    idle(0, 3);
    send(0, 64, 0, 0);
    idle(0, 70);

    // Random frames with random gaps and occasional fragments.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send(0, $urandom_range(1, 63), 2, 0);
        idle(0, $urandom_range(1, 3));
      end
      send(0, 64, 2, 0);
      gap = $urandom_range(0, 3);
      idle(0, gap);
    end
    idle(0, 70);

    // N=4, WIDTH=24: table-driven frame with extreme values.
    for (int i = 0; i < 4; i++) drive(1, 1'b0, 1'b1, tab[i].in_re, tab[i].in_im);
    drive(1, 1'b0, 1'b0, 24'd0, 24'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (oen[1]) begin
        cap_re.push_back(ore[1]);
        cap_im.push_back(oim[1]);
      end
    end
    check("tbl_count", 64'(cap_re.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tbl_pos%0d", tab[i].out_k),
            (tab[i].out_k < cap_re.size()) ? 64'({cap_re[tab[i].out_k], cap_im[tab[i].out_k]})
                                           : 64'hFFFF_FFFF_FFFF_FFFF,
            64'({tab[i].exp_re, tab[i].exp_im}));
    end
    send(1, 4, 0, 0);
    for (int i = 0; i < 5; i++) send(1, 4, 2, 0);
    send(1, 4, 3, 0);
    idle(1, 10);

    // N=1024, WIDTH=24: ordered, random, and extreme frames back to back.
    send(2, 1024, 0, 0);
    send(2, 1024, 2, 0);
    send(2, 1024, 3, 0);
    idle(2, 1030);

    for (int g = 0; g < NCFG; g++)
      check($sformatf("cfg%0d_drained", g), 64'(pending[g]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
